// File: rtl/mac_pkg.sv
// Shared types and sizing constants for the signed multiply-accumulate stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mac_pkg;

    localparam int MPLIER_W      = 32;
    localparam int PROD_W        = 2 * MPLIER_W;
    localparam int MAC_ACC_W_DEF = 72;
    localparam int MAC_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        HOLD
    } mac_state_e;

endpackage

// File: rtl/mplier32x32.sv
// Combinational 32x32 signed multiplier producing the full 64-bit product.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the surrounding pipeline registers own flow control.
module mplier32x32
    import mac_pkg::*;
(
    input  logic signed [MPLIER_W-1:0] a,
    input  logic signed [MPLIER_W-1:0] b,
    output logic signed [PROD_W-1:0]   product
);

    assign product = a * b;

endmodule

// File: rtl/mac_accumulator.sv
// Signed MAC: operand regs -> mplier32x32 -> product reg -> wide accumulator.
// Latency: out_valid rises 2 edges after the last-beat handshake edge.
// Backpressure: in_ready drops from the last beat until the held result is taken.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W = MAC_ACC_W_DEF,
    parameter int CNT_W = MAC_CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [MPLIER_W-1:0] in_a,
    input  logic signed [MPLIER_W-1:0] in_b,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_W-1:0]    out_acc,
    output logic        [CNT_W-1:0]    out_count,
    output logic                       out_overflow
);

    mac_state_e state_q, state_d;

    logic                       in_fire;
    logic                       a_vld, a_last;
    logic signed [MPLIER_W-1:0] a_a, a_b;
    logic signed [PROD_W-1:0]   product;
    logic                       b_vld, b_last;
    logic signed [PROD_W-1:0]   b_prod;
    logic signed [ACC_W-1:0]    acc, prod_ext, sum;
    logic        [CNT_W-1:0]    cnt, cnt_inc;
    logic                       ovf, ovf_now;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign in_fire   = in_valid && in_ready;

    mplier32x32 u_mplier (
        .a       (a_a),
        .b       (a_b),
        .product (product)
    );

    // Adder isolated in its own stage so the multiplier owns the critical path.
    assign prod_ext = ACC_W'(b_prod);
    assign sum      = acc + prod_ext;
    assign ovf_now  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACCUM;
            a_vld        <= 1'b0;
            a_last       <= 1'b0;
            a_a          <= '0;
            a_b          <= '0;
            b_vld        <= 1'b0;
            b_last       <= 1'b0;
            b_prod       <= '0;
            acc          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            out_acc      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            state_q <= state_d;

            a_vld <= in_fire;
            if (in_fire) begin
                a_a    <= in_a;
                a_b    <= in_b;
                a_last <= in_last;
            end

            b_vld  <= a_vld;
            b_last <= a_vld && a_last;
            if (a_vld) begin
                b_prod <= product;
            end

            if (b_vld) begin
                if (b_last) begin
                    out_acc      <= sum;
                    out_count    <= cnt_inc;
                    out_overflow <= ovf || ovf_now;
                    acc          <= '0;
                    cnt          <= '0;
                    ovf          <= 1'b0;
                end else begin
                    acc <= sum;
                    cnt <= cnt_inc;
                    ovf <= ovf || ovf_now;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (in_fire && in_last) state_d = DRAIN;
            DRAIN:   if (b_vld && b_last)    state_d = HOLD;
            HOLD:    if (out_ready)          state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Drives two widths (72 and 66) with identical stimulus, checks against an arithmetic model.
module tb_mac_accumulator;

    localparam logic signed [31:0] MINV = 32'sh8000_0000;
    localparam logic signed [31:0] MAXV = 32'sh7FFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               in_valid, in_last, out_ready;
    logic signed [31:0] in_a, in_b;
    logic               in_ready72, in_ready66, out_valid72, out_valid66;
    logic signed [71:0] out_acc72;
    logic signed [65:0] out_acc66;
    logic        [15:0] out_count72, out_count66;
    logic               ovf72, ovf66;

    int checks = 0;
    int errors = 0;
    logic signed [31:0] qa[$];
    logic signed [31:0] qb[$];

    mac_accumulator dut72 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready72),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid72),
        .out_ready(out_ready), .out_acc(out_acc72), .out_count(out_count72),
        .out_overflow(ovf72)
    );

    mac_accumulator #(.ACC_W(66)) dut66 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready66),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid66),
        .out_ready(out_ready), .out_acc(out_acc66), .out_count(out_count66),
        .out_overflow(ovf66)
    );

    // Reference: exact running sum wrapped into w bits, overflow whenever the exact sum leaves range.
    task automatic model_sum(input int w, output logic signed [127:0] acc, output int cnt, output bit ovf);
        logic signed [127:0] lim, p, t;
        lim = 128'sd1 <<< (w - 1);
        acc = 0; cnt = 0; ovf = 0;
        for (int i = 0; i < qa.size(); i++) begin
            p = longint'(qa[i]) * longint'(qb[i]);
            t = acc + p;
            if (t >= lim) begin t = t - 2 * lim; ovf = 1; end
            else if (t < -lim) begin t = t + 2 * lim; ovf = 1; end
            acc = t;
            if (cnt < 65535) cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive_sum(input bit bubbles, input bit check_lat);
        int lat;
        for (int i = 0; i < qa.size(); i++) begin
            if (bubbles && $urandom_range(0, 2) == 0) begin
                in_valid = 0; tick();
            end
            checks++;
            if (in_ready72 !== 1'b1 || in_ready66 !== 1'b1) begin
                errors++; $display("FAIL beat_ready: in_ready=%b/%b want 1", in_ready72, in_ready66);
            end
            in_valid = 1; in_a = qa[i]; in_b = qb[i]; in_last = (i == qa.size() - 1);
            tick();
        end
        in_valid = 0; in_last = 0; in_a = $urandom; in_b = $urandom;
        lat = 1;
        while (!out_valid72 && lat < 20) begin
            checks++;
            if (in_ready72 !== 1'b0 || in_ready66 !== 1'b0) begin
                errors++; $display("FAIL drain_ready: in_ready=%b/%b want 0 (cycle %0d)", in_ready72, in_ready66, lat);
            end
            tick(); lat++;
        end
        checks++;
        if (out_valid72 !== 1'b1 || out_valid66 !== 1'b1) begin
            errors++; $display("FAIL out_valid_timeout: out_valid=%b/%b want 1", out_valid72, out_valid66);
        end
        if (check_lat) begin
            checks++;
            if (lat != 3) begin
                errors++; $display("FAIL latency: got %0d cycles want 3", lat);
            end
        end
    endtask

    task automatic check_result(input int hold);
        logic signed [127:0] a72, a66;
        int c72, c66;
        bit o72, o66;
        model_sum(72, a72, c72, o72);
        model_sum(66, a66, c66, o66);
        checks++;
        if (out_acc72 !== a72[71:0] || out_count72 !== 16'(c72) || ovf72 !== o72) begin
            errors++; $display("FAIL result72: acc=%0d cnt=%0d ovf=%b want acc=%0d cnt=%0d ovf=%b",
                               out_acc72, out_count72, ovf72, $signed(a72[71:0]), c72, o72);
        end
        checks++;
        if (out_acc66 !== a66[65:0] || out_count66 !== 16'(c66) || ovf66 !== o66) begin
            errors++; $display("FAIL result66: acc=%0d cnt=%0d ovf=%b want acc=%0d cnt=%0d ovf=%b",
                               out_acc66, out_count66, ovf66, $signed(a66[65:0]), c66, o66);
        end
        out_ready = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (out_valid72 !== 1'b1 || out_acc72 !== a72[71:0] || in_ready72 !== 1'b0 || in_ready66 !== 1'b0) begin
                errors++; $display("FAIL hold_stable: vld=%b acc=%0d rdy=%b/%b want vld=1 acc=%0d rdy=0",
                                   out_valid72, out_acc72, in_ready72, in_ready66, $signed(a72[71:0]));
            end
        end
        out_ready = 1; tick(); out_ready = 0;
        checks++;
        if (out_valid72 !== 1'b0 || out_valid66 !== 1'b0 || in_ready72 !== 1'b1 || in_ready66 !== 1'b1) begin
            errors++; $display("FAIL handshake: out_valid=%b/%b in_ready=%b/%b want 0/0 1/1",
                               out_valid72, out_valid66, in_ready72, in_ready66);
        end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (out_valid72 !== 0 || out_valid66 !== 0 || in_ready72 !== 1 || in_ready66 !== 1 ||
            out_acc72 !== 0 || out_acc66 !== 0 || out_count72 !== 0 || out_count66 !== 0 ||
            ovf72 !== 0 || ovf66 !== 0) begin
            errors++; $display("FAIL %s: vld=%b/%b rdy=%b/%b acc=%0d/%0d cnt=%0d/%0d ovf=%b/%b want all 0, rdy 1",
                               tag, out_valid72, out_valid66, in_ready72, in_ready66, out_acc72, out_acc66,
                               out_count72, out_count66, ovf72, ovf66);
        end
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; in_last = 0; in_a = 0; in_b = 0; out_ready = 0;
        repeat (3) tick();
        rst = 0;
        check_idle("reset_state");
    endtask

    task automatic test_single_beat();
        qa = '{32'sd3}; qb = '{-32'sd4};
        drive_sum(0, 1);
        checks++;
        if (out_acc72 !== -72'sd12) begin
            errors++; $display("FAIL single_const: acc=%0d want -12", out_acc72);
        end
        check_result(0);
    endtask

    task automatic test_burst();
        qa = '{32'sd1000, -32'sd7, MAXV}; qb = '{32'sd1000, 32'sd6, 32'sd2};
        drive_sum(0, 1);
        checks++;
        if (out_acc72 !== 72'sd4295967252 || out_count72 !== 16'd3) begin
            errors++; $display("FAIL burst_const: acc=%0d cnt=%0d want 4295967252 3", out_acc72, out_count72);
        end
        check_result(2);
    endtask

    task automatic test_corner();
        qa = '{MINV}; qb = '{MINV};
        drive_sum(0, 1);
        checks++;
        if (out_acc72 !== 72'sd4611686018427387904) begin
            errors++; $display("FAIL corner_const: acc=%0d want 4611686018427387904", out_acc72);
        end
        check_result(0);
    endtask

    task automatic test_hold_backpressure();
        qa = '{-32'sd9, 32'sd123456}; qb = '{32'sd9, -32'sd77};
        drive_sum(0, 1);
        check_result(5);
        qa = '{32'sd5}; qb = '{32'sd5};
        drive_sum(0, 1);
        checks++;
        if (out_acc72 !== 72'sd25) begin
            errors++; $display("FAIL fresh_sum: acc=%0d want 25", out_acc72);
        end
        check_result(0);
    endtask

    task automatic test_overflow_w66();
        qa = {}; qb = {};
        repeat (8) begin qa.push_back(MINV); qb.push_back(MINV); end
        drive_sum(1, 0);
        checks++;
        if (out_acc66 !== (66'sd1 <<< 65) || ovf66 !== 1'b1 || out_count66 !== 16'd8 || ovf72 !== 1'b0) begin
            errors++; $display("FAIL ovf66_const: acc=%0d ovf=%b cnt=%0d ovf72=%b want -2^65 1 8 0",
                               out_acc66, ovf66, out_count66, ovf72);
        end
        check_result(1);
        qa = '{32'sd1}; qb = '{32'sd1};
        drive_sum(0, 1);
        checks++;
        if (ovf66 !== 1'b0) begin
            errors++; $display("FAIL ovf_cleared: ovf=%b want 0", ovf66);
        end
        check_result(0);
    endtask

    task automatic test_reset_mid_burst();
        in_valid = 1; in_last = 0; in_a = 32'sd11; in_b = 32'sd13; tick();
        in_a = -32'sd17; tick();
        in_valid = 0; rst = 1; tick(); rst = 0;
        check_idle("reset_mid_burst");
        repeat (4) tick();
        check_idle("no_output_after_reset");
        qa = '{32'sd2}; qb = '{32'sd3};
        drive_sum(0, 1);
        checks++;
        if (out_acc72 !== 72'sd6 || out_count72 !== 16'd1) begin
            errors++; $display("FAIL post_reset_sum: acc=%0d cnt=%0d want 6 1", out_acc72, out_count72);
        end
        check_result(0);
    endtask

    task automatic test_random();
        for (int s = 0; s < 12; s++) begin
            qa = {}; qb = {};
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
                qa.push_back(($urandom_range(0, 3) == 0) ? MINV : $urandom);
                qb.push_back(($urandom_range(0, 3) == 0) ? MAXV : $urandom);
            end
            drive_sum(1, 1);
            check_result($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_burst();
        test_corner();
        test_hold_backpressure();
        test_overflow_w66();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
